sdram_arb: RTL and testbench

Arbiter and refresh scheduler in front of one SDRAM controller channel. Two requesters share the channel: port 0 carries cartridge CPU/PPU fetches and port 1 carries the QSPI api loader. Selection is round-robin between the two ports. Periodic auto-refresh requests are injected, and each refresh can be postponed by a bounded amount while traffic is pending. The block drives the controller's request/ack channel and its refresh handshake, and it returns read data to the winning requester.

---
 rtl/sdram_arb.sv | 154 +++++++++++++++
 tb/tb_sdram_arb.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arb.sv
// sdram_arb: two-port round-robin arbiter with an auto-refresh scheduler in
// front of a single SDRAM controller channel. Port 0 serves cartridge
// CPU/PPU fetches and port 1 serves the QSPI loader. Refresh ticks are
// counted in `pending` and may be postponed up to MAX_POSTPONE ticks.
module sdram_arb #(
  parameter int ADDR_W           = 22,
  parameter int REFRESH_INTERVAL = 780,
  parameter int MAX_POSTPONE     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_done,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [15:0]       r0_wdata,
  output logic              r0_ack,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [15:0]       r1_wdata,
  output logic              r1_ack,
  output logic [15:0]       rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [15:0]       m_wdata,
  input  logic              m_ack,
  input  logic [15:0]       m_rdata,
  output logic              refresh_req,
  input  logic              refresh_done,
  output logic              overrun
);

  localparam int CNT_W  = $clog2(REFRESH_INTERVAL);
  localparam int PEND_W = $clog2(MAX_POSTPONE + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_INTERVAL - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_POSTPONE);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GRANT0  = 3'd1;
  localparam logic [2:0] S_GRANT1  = 3'd2;
  localparam logic [2:0] S_REFRESH = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [PEND_W-1:0] pending;
  logic              last;
  logic              tick;
  logic              rf_done;

  // A tick is the wrap of the interval counter; refresh_done only counts
  // while a refresh is actually outstanding.
  assign tick    = init_done && (cnt == CNT_LAST);
  assign rf_done = (state == S_REFRESH) && refresh_done;

  // Refresh interval counter, frozen at 0 until the SDRAM is initialised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (!init_done) cnt <= '0;
    else if (tick)       cnt <= '0;
    else                 cnt <= cnt + 1'b1;
  end

  // Outstanding refresh bookkeeping; a tick lost at saturation is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      overrun <= 1'b0;
    end else if (tick && !rf_done) begin
      if (pending == PEND_MAX) overrun <= 1'b1;
      else                     pending <= pending + 1'b1;
    end else if (!tick && rf_done && (pending != '0)) begin
      pending <= pending - 1'b1;
    end
  end

  // Arbitration FSM and registered controller/requester outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      last        <= 1'b1;
      m_req       <= 1'b0;
      m_we        <= 1'b0;
      m_addr      <= '0;
      m_wdata     <= '0;
      r0_ack      <= 1'b0;
      r1_ack      <= 1'b0;
      rdata       <= '0;
      refresh_req <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (init_done) begin
            if (pending == PEND_MAX) begin
              // Postponement budget exhausted: refresh beats traffic.
              state       <= S_REFRESH;
              refresh_req <= 1'b1;
            end else if (r0_req && (!r1_req || last)) begin
              state   <= S_GRANT0;
              m_req   <= 1'b1;
              m_we    <= r0_we;
              m_addr  <= r0_addr;
              m_wdata <= r0_wdata;
              last    <= 1'b0;
            end else if (r1_req) begin
              state   <= S_GRANT1;
              m_req   <= 1'b1;
              m_we    <= r1_we;
              m_addr  <= r1_addr;
              m_wdata <= r1_wdata;
              last    <= 1'b1;
            end else if (pending != '0) begin
              state       <= S_REFRESH;
              refresh_req <= 1'b1;
            end
          end
        end
        S_GRANT0: begin
          if (m_ack) begin
            m_req  <= 1'b0;
            r0_ack <= 1'b1;
            rdata  <= m_rdata;
            state  <= S_DONE;
          end
        end
        S_GRANT1: begin
          if (m_ack) begin
            m_req  <= 1'b0;
            r1_ack <= 1'b1;
            rdata  <= m_rdata;
            state  <= S_DONE;
          end
        end
        S_REFRESH: begin
          if (refresh_done) begin
            refresh_req <= 1'b0;
            state       <= S_IDLE;
          end
        end
        S_DONE: begin
          // Requests are ignored here so a requester dropping req at this
          // edge is not granted a second time.
          r0_ack <= 1'b0;
          r1_ack <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arb.sv
// tb_sdram_arb: randomized requesters and controller/refresh responders,
// a decision-level reference model and an ack scoreboard.
module tb_sdram_arb;
  localparam int AW = 22;
  localparam int RI = 24;
  localparam int MP = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init_done = 1'b0;
  logic          r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0;
  logic [15:0]   r0_wdata = '0, r1_wdata = '0;
  logic          r0_ack, r1_ack;
  logic [15:0]   rdata;
  logic          m_req, m_we;
  logic [AW-1:0] m_addr;
  logic [15:0]   m_wdata;
  logic          m_ack = 1'b0;
  logic [15:0]   m_rdata = '0;
  logic          refresh_req;
  logic          refresh_done = 1'b0;
  logic          overrun;

  always #5 clk = ~clk;

  sdram_arb #(.ADDR_W(AW), .REFRESH_INTERVAL(RI), .MAX_POSTPONE(MP)) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_ack(r0_ack),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_ack(r1_ack),
    .rdata(rdata), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .refresh_req(refresh_req),
    .refresh_done(refresh_done), .overrun(overrun)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Responder controls
  bit rf_en = 1'b1, spur_en = 1'b0, fixed_lat = 1'b0, hold = 1'b0;
  int mlat = 0, rlat = 0;

  // SDRAM controller model: random access latency, optional stray acks.
  always @(negedge clk) begin
    m_ack = 1'b0;
    if (!rst_n) mlat = 0;
    else if (m_req && !hold) begin
      if (mlat == 0) mlat = fixed_lat ? 5 : $urandom_range(1, 6);
      mlat--;
      if (mlat == 0) begin
        m_ack   = 1'b1;
        m_rdata = fixed_lat ? 16'hBEEF : 16'($urandom);
      end
    end else if (!m_req && spur_en && $urandom_range(0, 9) == 0) begin
      m_ack   = 1'b1;
      m_rdata = 16'($urandom);
    end
  end

  // Refresh completion model: random latency, optional stray pulses.
  always @(negedge clk) begin
    refresh_done = 1'b0;
    if (!rst_n) rlat = 0;
    else if (refresh_req && rf_en) begin
      if (rlat == 0) rlat = $urandom_range(1, 4);
      rlat--;
      if (rlat == 0) refresh_done = 1'b1;
    end else if (!refresh_req && spur_en && $urandom_range(0, 9) == 0) begin
      refresh_done = 1'b1;
    end
  end

  // Reference model state
  int          exp_port_q[$];
  logic [15:0] exp_data_q[$];
  int          grant_log[$];
  bit          mreq_p, rf_p, ack_p, ov_m;
  int          pend, ec, last_m, gport, rf_rises;
  logic [AW-1:0] la;
  logic        lw;
  logic [15:0] ld;
  logic          r0c, r1c, w0c, w1c, idc, mac, rdc;
  logic [AW-1:0] a0c, a1c;
  logic [15:0]   d0c, d1c, mdc;
  int          exp_k, exp_kind, obs_k;
  bit          idle_p, tk, dn;

  // Decision model: at every edge where the block was idle, derive the
  // expected outcome from the priority rules; track pending/overrun by
  // counting ticks and completed refreshes.
  always @(posedge clk) begin
    if (!rst_n) begin
      mreq_p = 0; rf_p = 0; ack_p = 0; ov_m = 0;
      pend = 0; ec = 0; last_m = 1; gport = 0;
      exp_port_q.delete(); exp_data_q.delete();
    end else begin
      r0c = r0_req; r1c = r1_req; w0c = r0_we; w1c = r1_we;
      a0c = r0_addr; a1c = r1_addr; d0c = r0_wdata; d1c = r1_wdata;
      idc = init_done; mac = m_ack; mdc = m_rdata; rdc = refresh_done;
      idle_p = !mreq_p && !rf_p && !ack_p;
      exp_k = 0;
      if (idc && idle_p) begin
        if (pend == MP)         exp_k = 3;
        else if (r0c && r1c)    exp_k = (last_m == 0) ? 2 : 1;
        else if (r0c)           exp_k = 1;
        else if (r1c)           exp_k = 2;
        else if (pend > 0)      exp_k = 3;
      end
      tk = 0;
      if (!idc) ec = 0;
      else if (ec == RI - 1) begin ec = 0; tk = 1; end
      else ec++;
      dn = rdc && rf_p;
      if (tk && !dn) begin
        if (pend == MP) ov_m = 1; else pend++;
      end else if (!tk && dn && pend > 0) pend--;
      if (mac && mreq_p) begin
        exp_port_q.push_back(gport);
        exp_data_q.push_back(mdc);
      end
      #1;
      obs_k = (refresh_req && !rf_p) ? 3 : (m_req && !mreq_p) ? 1 : 0;
      exp_kind = (exp_k == 1 || exp_k == 2) ? 1 : exp_k;
      if (idle_p || obs_k != 0) chk("decision", obs_k, exp_kind);
      if (obs_k == 3) rf_rises++;
      if (obs_k == 1 && exp_kind == 1) begin
        gport  = exp_k - 1;
        last_m = gport;
        grant_log.push_back(gport);
        chk("grant_addr",  m_addr,  gport ? a1c : a0c);
        chk("grant_we",    m_we,    gport ? w1c : w0c);
        chk("grant_wdata", m_wdata, gport ? d1c : d0c);
        la = m_addr; lw = m_we; ld = m_wdata;
      end else if (m_req && mreq_p) begin
        chk("stable_addr", m_addr, la);
        chk("stable_we", m_we, lw);
        chk("stable_wdata", m_wdata, ld);
      end
      chk("mutex", m_req && refresh_req, 0);
      chk("overrun", overrun, ov_m);
      mreq_p = m_req; rf_p = refresh_req; ack_p = r0_ack || r1_ack;
    end
  end

  // Ack monitor: every requester ack must match the next scoreboard entry.
  always @(negedge clk) begin
    int p;
    logic [15:0] d;
    if (rst_n) begin
      if (r0_ack || r1_ack) begin
        if (exp_port_q.size() == 0) chk("spurious_ack", {r1_ack, r0_ack}, 0);
        else begin
          p = exp_port_q.pop_front();
          d = exp_data_q.pop_front();
          chk("ack_port", {r1_ack, r0_ack}, (p == 0) ? 2'b01 : 2'b10);
          chk("ack_rdata", rdata, d);
        end
      end else if (exp_port_q.size() != 0) begin
        chk("missing_ack", 0, 1);
        p = exp_port_q.pop_front();
        d = exp_data_q.pop_front();
      end
    end
  end

  task automatic drive(input int p, input bit rq, input bit we, input logic [AW-1:0] a, input logic [15:0] d);
    if (p == 0) begin r0_req = rq; r0_we = we; r0_addr = a; r0_wdata = d; end
    else        begin r1_req = rq; r1_we = we; r1_addr = a; r1_wdata = d; end
  endtask

  // Hold a request until its ack is seen; the caller updates req in the
  // same cycle (DONE) so it is never re-granted.
  task automatic do_req(input int p, input bit we, input logic [AW-1:0] a, input logic [15:0] d,
                        output logic [15:0] rd);
    bit got = 0;
    rd = '0;
    drive(p, 1'b1, we, a, d);
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if ((p == 0) ? r0_ack : r1_ack) begin got = 1; rd = rdata; end
    end
    chk("req_served", got, 1);
  endtask

  task automatic req_stream(input int p, input int n, input int maxgap);
    logic [15:0] rd;
    int gap;
    for (int k = 0; k < n; k++) begin
      do_req(p, 1'($urandom), AW'($urandom), 16'($urandom), rd);
      gap = $urandom_range(0, maxgap);
      if (gap > 0 || k == n - 1) begin
        drive(p, 1'b0, 1'b0, '0, '0);
        repeat (gap) @(negedge clk);
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m_req"}, m_req, 0);
    chk({tag, "_refresh_req"}, refresh_req, 0);
    chk({tag, "_r0_ack"}, r0_ack, 0);
    chk({tag, "_r1_ack"}, r1_ack, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_m_addr"}, m_addr, 0);
    chk({tag, "_m_we"}, m_we, 0);
    chk({tag, "_m_wdata"}, m_wdata, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    bit seen;
    int base;
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Requests while uninitialised must be ignored; counter held at 0.
    drive(0, 1'b1, 1'b0, 22'h111, 16'h0);
    drive(1, 1'b1, 1'b1, 22'h222, 16'h5A5A);
    repeat (3 * RI) @(negedge clk);
    chk("init_hold", m_req | refresh_req, 0);

    // Both ports saturating from reset: grants alternate starting at port 0.
    init_done = 1'b1;
    fork
      req_stream(0, 6, 0);
      req_stream(1, 6, 0);
    join
    chk("rr_first", grant_log[0], 0);
    chk("rr_second", grant_log[1], 1);
    chk("rr_third", grant_log[2], 0);
    chk("rr_fourth", grant_log[3], 1);
    repeat (4) @(negedge clk);

    // Directed single read on port 0.
    fixed_lat = 1'b1;
    fork
      begin
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
          @(negedge clk);
          if (m_req) seen = 1;
        end
        chk("dir_m_req", seen, 1);
        chk("dir_m_addr", m_addr, 22'h12345);
        chk("dir_m_we", m_we, 0);
      end
      do_req(0, 1'b0, 22'h12345, 16'h0, rd);
    join
    drive(0, 1'b0, 1'b0, '0, '0);
    chk("dir_rdata", rd, 16'hBEEF);
    fixed_lat = 1'b0;
    repeat (4) @(negedge clk);

    // Random traffic with stray m_ack/refresh_done pulses.
    spur_en = 1'b1;
    fork
      req_stream(0, 40, 3);
      req_stream(1, 40, 3);
    join
    spur_en = 1'b0;
    repeat (4) @(negedge clk);

    // Saturation: refreshes must still get through via the postpone limit.
    base = rf_rises;
    fork
      req_stream(0, 40, 0);
      req_stream(1, 40, 0);
    join
    chk("sat_refreshed", rf_rises > base, 1);
    repeat (4) @(negedge clk);

    // Overrun: controller never finishes refresh.
    rf_en = 1'b0;
    seen = 0;
    for (int i = 0; i < 6 * RI && !seen; i++) begin
      @(negedge clk);
      if (overrun) seen = 1;
    end
    chk("overrun_set", overrun, 1);
    rf_en = 1'b1;
    repeat (3 * RI) @(negedge clk);
    chk("overrun_sticky", overrun, 1);

    // Reset in the middle of a port 1 access.
    hold = 1'b1;
    drive(1, 1'b1, 1'b0, 22'h3ABCD, 16'h0);
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (m_req) seen = 1;
    end
    chk("mid_grant", seen, 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    init_done = 1'b0;
    hold = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_no_init", m_req | refresh_req, 0);
    drive(1, 1'b0, 1'b0, '0, '0);
    init_done = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_no_req", m_req | refresh_req, 0);
    do_req(1, 1'b1, 22'h00042, 16'hCAFE, rd);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
